// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core width plus unified memory arbiter state and owner encodings
package riscv_pkg;
    localparam int XLEN = 32;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_DATA, OWN_FETCH, OWN_DBG} arb_owner_t;
endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: picks the next memory owner; fetch wins when data is idle or fetch has starved
module mem_arb_prio import riscv_pkg::*; #(
    parameter int CW = 3,
    parameter int STARVE_MAX = 4
) (
    input  logic          d_req,
    input  logic          i_req,
    input  logic          dbg_req,
    input  logic [CW-1:0] starve_cnt,
    output arb_owner_t    win
);
    always_comb
        win = (i_req && (starve_cnt == CW'(STARVE_MAX) || !d_req)) ? OWN_FETCH :
              d_req ? OWN_DATA : dbg_req ? OWN_DBG : OWN_NONE;
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one fixed-latency single-port memory between data, fetch and debug
module unified_mem_arbiter #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int MEM_LAT = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [XLEN-1:0] d_addr_i,
    input  logic [XLEN-1:0] d_wdata_i,
    input  logic [3:0]      d_be_i,
    output logic            d_gnt_o,
    output logic            d_rvalid_o,
    output logic [XLEN-1:0] d_rdata_o,
    input  logic            i_req_i,
    input  logic [XLEN-1:0] i_addr_i,
    output logic            i_gnt_o,
    output logic            i_rvalid_o,
    output logic [XLEN-1:0] i_rdata_o,
    input  logic            dbg_req_i,
    input  logic [XLEN-1:0] dbg_addr_i,
    output logic            dbg_gnt_o,
    output logic            dbg_rvalid_o,
    output logic [XLEN-1:0] dbg_rdata_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [3:0]      mem_be_o,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            busy_o
);
    import riscv_pkg::*;
    localparam int LW = $clog2(MEM_LAT + 1);
    localparam int CW = $clog2(STARVE_MAX + 1);
    arb_state_t      state;
    arb_owner_t      owner;
    arb_owner_t      win;
    logic [LW-1:0]   lat_cnt;
    logic [CW-1:0]   starve_cnt;
    logic            we_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [3:0]      be_q;
    logic            arb;
    logic            gnt;
    mem_arb_prio #(.CW(CW), .STARVE_MAX(STARVE_MAX)) u_prio (
        .d_req      (d_req_i),
        .i_req      (i_req_i),
        .dbg_req    (dbg_req_i),
        .starve_cnt (starve_cnt),
        .win        (win)
    );
    // no grant is offered while reset is held so nothing is accepted and then dropped
    assign arb          = !rst_i && (state == ARB_IDLE || state == ARB_RESP);
    assign gnt          = arb && win != OWN_NONE;
    assign d_gnt_o      = arb && win == OWN_DATA;
    assign i_gnt_o      = arb && win == OWN_FETCH;
    assign dbg_gnt_o    = arb && win == OWN_DBG;
    assign d_rvalid_o   = state == ARB_RESP && owner == OWN_DATA;
    assign i_rvalid_o   = state == ARB_RESP && owner == OWN_FETCH;
    assign dbg_rvalid_o = state == ARB_RESP && owner == OWN_DBG;
    assign mem_req_o    = state == ARB_ISSUE;
    assign mem_we_o     = mem_req_o && we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_be_o     = be_q;
    assign busy_o       = state != ARB_IDLE;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ARB_IDLE;
            owner       <= OWN_NONE;
            lat_cnt     <= '0;
            starve_cnt  <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            d_rdata_o   <= '0;
            i_rdata_o   <= '0;
            dbg_rdata_o <= '0;
        end else begin
            case (state)
                ARB_IDLE, ARB_RESP: begin
                    state <= gnt ? ARB_ISSUE : ARB_IDLE;
                    owner <= win;
                    if (gnt) begin
                        we_q    <= win == OWN_DATA && d_we_i;
                        addr_q  <= (win == OWN_DATA ? d_addr_i : win == OWN_FETCH ? i_addr_i : dbg_addr_i) & ~XLEN'(3);
                        wdata_q <= win == OWN_DATA ? d_wdata_i : '0;
                        be_q    <= win == OWN_DATA ? d_be_i : 4'hF;
                    end
                    if (win == OWN_FETCH)
                        starve_cnt <= '0;
                    else if (win == OWN_DATA)
                        starve_cnt <= !i_req_i ? '0 : starve_cnt == CW'(STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1;
                end
                ARB_ISSUE: begin
                    state   <= ARB_WAIT;
                    lat_cnt <= LW'(MEM_LAT);
                end
                default: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt == LW'(1)) begin
                        state <= ARB_RESP;
                        if (!we_q && owner == OWN_DATA) d_rdata_o <= mem_rdata_i;
                        if (!we_q && owner == OWN_FETCH) i_rdata_o <= mem_rdata_i;
                        if (!we_q && owner == OWN_DBG) dbg_rdata_o <= mem_rdata_i;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: scoreboard bench with a latency-2 memory model behind the arbiter
module tb_unified_mem_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        d_req_i = 1'b0, d_we_i = 1'b0;
    logic [31:0] d_addr_i = '0, d_wdata_i = '0;
    logic [3:0]  d_be_i = '0;
    logic        d_gnt_o, d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        i_req_i = 1'b0;
    logic [31:0] i_addr_i = '0;
    logic        i_gnt_o, i_rvalid_o;
    logic [31:0] i_rdata_o;
    logic        dbg_req_i = 1'b0;
    logic [31:0] dbg_addr_i = '0;
    logic        dbg_gnt_o, dbg_rvalid_o;
    logic [31:0] dbg_rdata_o;
    logic        mem_req_o, mem_we_o, busy_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_be_o;
    int          checks = 0, failures = 0;
    logic [31:0] q_d[$], q_i[$], q_g[$];
    logic [31:0] ref_mem [0:255];
    logic [31:0] last_d = '0;
    always #5 clk_i = ~clk_i;
    unified_mem_arbiter #(.XLEN(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_be_i(d_be_i),
        .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o), .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
        .dbg_req_i(dbg_req_i), .dbg_addr_i(dbg_addr_i), .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o),
        .dbg_rdata_o(dbg_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );
    function automatic logic [31:0] init_word(int k);
        return k == 4 ? 32'h00500093 : 32'hA5C30000 | 32'(k * 4);
    endfunction
    // memory: data is only valid exactly two cycles after the strobe, garbage otherwise
    logic [31:0] mem [0:255];
    logic        mem_ready = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic [31:0] p1 = '0, p2 = '0;
    always @(posedge clk_i) begin
        if (!mem_ready) begin
            for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
            mem_ready <= 1'b1;
        end else if (mem_req_o && mem_we_o)
            for (int b = 0; b < 4; b++) if (mem_be_o[b]) mem[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        v1 <= mem_req_o && !mem_we_o;
        p1 <= mem[mem_addr_o[9:2]];
        v2 <= v1;
        p2 <= p1;
    end
    assign mem_rdata_i = v2 ? p2 : 32'hBAD0BAD0;
    task automatic monitor();
        logic [31:0] e;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                checks++;
                if (32'(d_gnt_o) + 32'(i_gnt_o) + 32'(dbg_gnt_o) > 1) begin
                    failures++; $display("FAIL onehot_gnt got d=%0b i=%0b dbg=%0b, at most one allowed", d_gnt_o, i_gnt_o, dbg_gnt_o);
                end
                if (mem_req_o) begin
                    checks++;
                    if (mem_addr_o[1:0] !== 2'b00) begin failures++; $display("FAIL mem_addr_align got %h", mem_addr_o); end
                end
                if (d_rvalid_o) begin
                    checks++;
                    if (q_d.size() == 0) begin failures++; $display("FAIL d_rvalid unexpected, rdata=%h", d_rdata_o); end
                    else begin
                        e = q_d.pop_front();
                        if (d_rdata_o !== e) begin failures++; $display("FAIL d_rdata got %h expected %h", d_rdata_o, e); end
                    end
                end
                if (i_rvalid_o) begin
                    checks++;
                    if (q_i.size() == 0) begin failures++; $display("FAIL i_rvalid unexpected, rdata=%h", i_rdata_o); end
                    else begin
                        e = q_i.pop_front();
                        if (i_rdata_o !== e) begin failures++; $display("FAIL i_rdata got %h expected %h", i_rdata_o, e); end
                    end
                end
                if (dbg_rvalid_o) begin
                    checks++;
                    if (q_g.size() == 0) begin failures++; $display("FAIL dbg_rvalid unexpected, rdata=%h", dbg_rdata_o); end
                    else begin
                        e = q_g.pop_front();
                        if (dbg_rdata_o !== e) begin failures++; $display("FAIL dbg_rdata got %h expected %h", dbg_rdata_o, e); end
                    end
                end
            end
        end
    endtask
    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk_i); n++; end while (busy_o && n < 50);
        if (busy_o) begin checks++; failures++; $display("FAIL idle_timeout busy_o=%0b expected 0", busy_o); end
    endtask
    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({busy_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, d_gnt_o, i_gnt_o, dbg_gnt_o,
             d_rvalid_o, i_rvalid_o, dbg_rvalid_o} !== '0) begin
            failures++; $display("FAIL reset_ctrl busy=%0b mem_req=%0b be=%h addr=%h, all expected 0", busy_o, mem_req_o, mem_be_o, mem_addr_o);
        end
        checks++;
        if ({d_rdata_o, i_rdata_o, dbg_rdata_o} !== '0) begin
            failures++; $display("FAIL reset_rdata got %h %h %h expected 0", d_rdata_o, i_rdata_o, dbg_rdata_o);
        end
    endtask
    task automatic test_single_fetch();
        wait_idle();
        @(posedge clk_i);
        #1 i_req_i = 1'b1;
        i_addr_i = 32'h10;
        q_i.push_back(ref_mem[4]);
        @(negedge clk_i);
        checks++;
        if (i_gnt_o !== 1'b1) begin failures++; $display("FAIL fetch_gnt got %0b expected 1", i_gnt_o); end
        @(posedge clk_i);
        #1 i_req_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_be_o} !== {1'b1, 1'b0, 32'h10, 4'hF}) begin
            failures++; $display("FAIL fetch_issue got req=%0b we=%0b addr=%h be=%h expected 1 0 00000010 f", mem_req_o, mem_we_o, mem_addr_o, mem_be_o);
        end
        repeat (2) begin
            @(negedge clk_i);
            checks++;
            if (i_rvalid_o !== 1'b0) begin failures++; $display("FAIL fetch_early_rvalid got %0b expected 0", i_rvalid_o); end
        end
        @(negedge clk_i);
        checks++;
        if (i_rvalid_o !== 1'b1 || i_rdata_o !== 32'h00500093) begin
            failures++; $display("FAIL fetch_resp got rvalid=%0b rdata=%h expected 1 00500093", i_rvalid_o, i_rdata_o);
        end
    endtask
    task automatic test_load_vs_fetch();
        wait_idle();
        @(posedge clk_i);
        #1 d_req_i = 1'b1;
        d_we_i = 1'b0;
        d_addr_i = 32'h100;
        i_req_i = 1'b1;
        i_addr_i = 32'h20;
        q_d.push_back(ref_mem[64]);
        q_i.push_back(ref_mem[8]);
        last_d = ref_mem[64];
        @(negedge clk_i);
        checks++;
        if ({d_gnt_o, i_gnt_o, dbg_gnt_o} !== 3'b100) begin
            failures++; $display("FAIL data_first got gnt d,i,dbg=%b expected 100", {d_gnt_o, i_gnt_o, dbg_gnt_o});
        end
        @(posedge clk_i);
        #1 d_req_i = 1'b0;
        repeat (3) @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({d_rvalid_o, i_gnt_o} !== 2'b11) begin
            failures++; $display("FAIL fetch_in_resp got d_rvalid=%0b i_gnt=%0b expected 1 1", d_rvalid_o, i_gnt_o);
        end
        @(posedge clk_i);
        #1 i_req_i = 1'b0;
    endtask
    task automatic test_starvation();
        logic [5:0] seq = '0;
        int got = 0, n = 0;
        wait_idle();
        @(posedge clk_i);
        #1 d_req_i = 1'b1;
        d_we_i = 1'b0;
        d_addr_i = 32'h104;
        i_req_i = 1'b1;
        i_addr_i = 32'h24;
        while (got < 6 && n < 100) begin
            @(negedge clk_i);
            n++;
            if (d_gnt_o) begin
                q_d.push_back(ref_mem[65]); last_d = ref_mem[65]; seq = {seq[4:0], 1'b1}; got++;
            end else if (i_gnt_o) begin
                q_i.push_back(ref_mem[9]); seq = {seq[4:0], 1'b0}; got++;
            end
        end
        @(posedge clk_i);
        #1 d_req_i = 1'b0;
        i_req_i = 1'b0;
        checks++;
        if (seq !== 6'b111101) begin failures++; $display("FAIL starve_order got %b expected 111101 (1=data)", seq); end
    endtask
    task automatic test_store();
        wait_idle();
        @(posedge clk_i);
        #1 d_req_i = 1'b1;
        d_we_i = 1'b1;
        d_addr_i = 32'h203;
        d_wdata_i = 32'hDEADBEEF;
        d_be_i = 4'b0011;
        q_d.push_back(last_d);
        ref_mem[128][15:0] = 16'hBEEF;
        @(negedge clk_i);
        checks++;
        if (d_gnt_o !== 1'b1) begin failures++; $display("FAIL store_gnt got %0b expected 1", d_gnt_o); end
        @(posedge clk_i);
        #1 d_req_i = 1'b0;
        d_we_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o} !== {1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 4'b0011}) begin
            failures++; $display("FAIL store_issue got req=%0b we=%0b addr=%h wdata=%h be=%b expected 1 1 00000200 deadbeef 0011",
                                 mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o);
        end
        repeat (2) @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if (d_rvalid_o !== 1'b1 || d_rdata_o !== last_d) begin
            failures++; $display("FAIL store_ack got rvalid=%0b rdata=%h expected 1 %h", d_rvalid_o, d_rdata_o, last_d);
        end
        wait_idle();
        @(posedge clk_i);
        #1 d_req_i = 1'b1;
        d_addr_i = 32'h200;
        q_d.push_back(ref_mem[128]);
        last_d = ref_mem[128];
        @(negedge clk_i);
        checks++;
        if (d_gnt_o !== 1'b1) begin failures++; $display("FAIL readback_gnt got %0b expected 1", d_gnt_o); end
        @(posedge clk_i);
        #1 d_req_i = 1'b0;
    endtask
    task automatic test_debug();
        wait_idle();
        @(posedge clk_i);
        #1 i_req_i = 1'b1;
        i_addr_i = 32'h28;
        dbg_req_i = 1'b1;
        dbg_addr_i = 32'h46;
        q_i.push_back(ref_mem[10]);
        @(negedge clk_i);
        checks++;
        if ({d_gnt_o, i_gnt_o, dbg_gnt_o} !== 3'b010) begin
            failures++; $display("FAIL dbg_blocked0 got gnt d,i,dbg=%b expected 010", {d_gnt_o, i_gnt_o, dbg_gnt_o});
        end
        repeat (3) @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({d_gnt_o, i_gnt_o, dbg_gnt_o} !== 3'b010) begin
            failures++; $display("FAIL dbg_blocked1 got gnt d,i,dbg=%b expected 010", {d_gnt_o, i_gnt_o, dbg_gnt_o});
        end
        q_i.push_back(ref_mem[10]);
        @(posedge clk_i);
        #1 i_req_i = 1'b0;
        repeat (3) @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if ({i_rvalid_o, dbg_gnt_o} !== 2'b11) begin
            failures++; $display("FAIL dbg_gnt got i_rvalid=%0b dbg_gnt=%0b expected 1 1", i_rvalid_o, dbg_gnt_o);
        end
        q_g.push_back(ref_mem[17]);
        @(posedge clk_i);
        #1 dbg_req_i = 1'b0;
        repeat (3) @(negedge clk_i);
        @(negedge clk_i);
        checks++;
        if (dbg_rvalid_o !== 1'b1 || dbg_rdata_o !== 32'hA5C30044) begin
            failures++; $display("FAIL dbg_resp got rvalid=%0b rdata=%h expected 1 a5c30044", dbg_rvalid_o, dbg_rdata_o);
        end
    endtask
    task automatic test_reset_mid();
        wait_idle();
        @(posedge clk_i);
        #1 i_req_i = 1'b1;
        i_addr_i = 32'h30;
        @(negedge clk_i);
        checks++;
        if (i_gnt_o !== 1'b1) begin failures++; $display("FAIL abort_gnt got %0b expected 1", i_gnt_o); end
        @(posedge clk_i);
        #1 i_req_i = 1'b0;
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        last_d = '0;
        @(negedge clk_i);
        checks++;
        if ({busy_o, d_gnt_o, i_gnt_o, dbg_gnt_o, d_rvalid_o, i_rvalid_o, dbg_rvalid_o} !== 7'b0) begin
            failures++; $display("FAIL abort_state got busy=%0b i_gnt=%0b i_rvalid=%0b expected all 0", busy_o, i_gnt_o, i_rvalid_o);
        end
        repeat (5) begin
            @(negedge clk_i);
            checks++;
            if ({d_rvalid_o, i_rvalid_o, dbg_rvalid_o} !== 3'b0) begin
                failures++; $display("FAIL abort_rvalid got %b expected 000", {d_rvalid_o, i_rvalid_o, dbg_rvalid_o});
            end
        end
        test_single_fetch();
    endtask
    initial begin
        for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
        fork monitor(); join_none
        test_reset();
        test_single_fetch();
        test_load_vs_fetch();
        test_starvation();
        test_store();
        test_debug();
        test_reset_mid();
        wait_idle();
        repeat (2) @(negedge clk_i);
        checks++;
        if (q_d.size() + q_i.size() + q_g.size() != 0) begin
            failures++; $display("FAIL pending_responses got d=%0d i=%0d dbg=%0d expected 0", q_d.size(), q_i.size(), q_g.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview: Shares one single-port, fixed-latency unified memory between three requesters: the pipeline data port (load/store), the instruction fetch port, and the debug read port (addr_i/data_o path). Accepts one transaction at a time, sequences it through issue/wait/response states, and returns read data to the granted owner. Data has priority over fetch. A starvation counter guarantees fetch progress. Debug is served only when both core ports are idle.

Parameters:
XLEN, riscv_pkg::XLEN (32), address/data width
MEM_LAT, 2, cycles from mem_req_o to valid mem_rdata_i (>=1)
STARVE_MAX, 4, consecutive data grants with fetch pending before fetch is forced to win (>=1)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
d_req_i  in  1  data request (held until d_gnt_o)
d_we_i  in  1  data write enable
d_addr_i  in  XLEN  data byte address
d_wdata_i  in  XLEN  store data
d_be_i  in  4  store byte enables
d_gnt_o  out  1  data request accepted
d_rvalid_o  out  1  data response (load data or write ack)
d_rdata_o  out  XLEN  load data
i_req_i  in  1  fetch request
i_addr_i  in  XLEN  fetch address
i_gnt_o  out  1  fetch accepted
i_rvalid_o  out  1  fetch response
i_rdata_o  out  XLEN  instruction word
dbg_req_i  in  1  debug read request
dbg_addr_i  in  XLEN  debug address
dbg_gnt_o  out  1  debug accepted
dbg_rvalid_o  out  1  debug response
dbg_rdata_o  out  XLEN  debug read data
mem_req_o  out  1  memory access strobe (one cycle)
mem_we_o  out  1  memory write
mem_addr_o  out  XLEN  word-aligned address ([1:0] forced 0)
mem_wdata_o  out  XLEN  write data
mem_be_o  out  4  byte enables (4'hF for reads)
mem_rdata_i  in  XLEN  memory read data, valid MEM_LAT cycles after mem_req_o
busy_o  out  1  transaction in flight (state != IDLE)

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. Reset: state=IDLE, owner=NONE, starve_cnt=0, lat_cnt=0. All outputs 0.
- Arbitration happens in IDLE and RESP only. Grants are combinational from req and state; at most one gnt is high per cycle.
- Winner: fetch if i_req_i && (starve_cnt==STARVE_MAX || !d_req_i). Else data if d_req_i. Else debug if dbg_req_i.
- On grant: latch owner, we, addr, wdata, be (be=4'hF and we=0 for fetch/debug). Next state is ISSUE.
- ISSUE: mem_req_o=1 for exactly one cycle with latched fields. lat_cnt loads MEM_LAT. Next state is WAIT.
- WAIT: lat_cnt decrements each cycle. When lat_cnt==1, capture mem_rdata_i into the owner's rdata register; next state is RESP.
- RESP: owner's rvalid_o=1 for one cycle. rdata holds until the next response to that owner. A write gives an rvalid ack with rdata unchanged. A new grant may be issued in this same cycle (RESP to ISSUE); otherwise next state is IDLE.
- Latency: gnt at cycle T, mem_req_o at T+1, rvalid at T+2+MEM_LAT. Back-to-back throughput is one transaction per MEM_LAT+2 cycles.
- Starvation: starve_cnt increments (saturating at STARVE_MAX) on each data grant while i_req_i=1. It clears on a fetch grant, or on any data grant while i_req_i=0.
- Debug has no starvation guarantee.
- A requester must hold req and payload stable until its gnt. A req dropped before grant is simply not served.
- Reset mid-transaction: the next cycle is IDLE and no rvalid is produced for the aborted access. Memory writes already issued are not undone.
- mem_addr_o[1:0] is always 0. Misaligned inputs are silently aligned.

Decomposition:
- riscv_pkg gains typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP}.
- riscv_pkg gains typedef enum logic [1:0] arb_owner_t {OWN_NONE, OWN_DATA, OWN_FETCH, OWN_DBG}.
- One sub-module, mem_arb_prio: combinational winner select from d_req/i_req/dbg_req/starve_cnt, returning arb_owner_t.
- FSM, latency counter, and response registers live in unified_mem_arbiter.

Test Plan:
- Single fetch, MEM_LAT=2: i_req_i=1 with i_addr_i=0x10 at cycle 0 → i_gnt_o at 0; mem_req_o at 1 with addr 0x10; memory returns 0x00500093; i_rvalid_o=1 with i_rdata_o=0x00500093 at cycle 4.
- Simultaneous d_req_i (load 0x100) and i_req_i → d_gnt_o first. The fetch grant coincides with d_rvalid_o in RESP.
- Starvation, STARVE_MAX=4: d_req_i and i_req_i held continuously → grant order D,D,D,D,F,D,…
- Store d_addr_i=0x203, d_wdata_i=0xDEADBEEF, d_be_i=4'b0011 → mem_addr_o=0x200, mem_we_o=1, mem_be_o=4'b0011; ack d_rvalid_o 3 cycles later with d_rdata_o unchanged.
- Debug only when idle: dbg_req_i with i_req_i high → no dbg_gnt_o. Drop i_req_i → dbg_gnt_o next arbitration cycle, dbg_rdata_o = memory word.
- rst_i asserted in WAIT → next cycle busy_o=0, all gnt/rvalid stay 0, and a fresh fetch is served normally afterwards.
